weight_mem_writer: RTL

WEIGHT_MEM_WRITER -- requirements
Module: weight_mem_writer

---
 rtl/weight_mem_writer_if.sv | 28 ++
 rtl/weight_mem_writer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/weight_mem_writer_if.sv
// Weight-stream handshake bundle feeding the weight-memory packer.
//   s_valid_i : producer has a weight on s_data_i
//   s_data_i  : one signed weight
//   s_last_i  : final weight of the stream
//   s_ready_o : packer accepts a weight this cycle
// master = weight producer, slave = weight_mem_writer.
interface weight_mem_writer_if #(
  parameter int F_WIDTH = 8
) ();
  logic               s_valid_i;
  logic [F_WIDTH-1:0] s_data_i;
  logic               s_last_i;
  logic               s_ready_o;

  modport master (
    output s_valid_i,
    output s_data_i,
    output s_last_i,
    input  s_ready_o
  );

  modport slave (
    input  s_valid_i,
    input  s_data_i,
    input  s_last_i,
    output s_ready_o
  );
endinterface

// File: rtl/weight_mem_writer.sv
// Packs a stream of weights into N_ROWS_ARRAY-lane words and writes them to
// the weight memory at consecutive addresses, starting at base_addr_i.
//
// state | meaning
// IDLE  | waiting for start_i, stream not ready
// PACK  | accepting weights into the pack buffer, one lane per transfer
// WRITE | one-cycle memory write of the registered word
// DONE  | one-cycle completion pulse, overflow detection at the word limit
//
// Ports:
//   clk_i, rd_weight_rst       : clock, async active-high reset
//   start_i                    : start pulse (IDLE only)
//   base_addr_i, max_words_i   : first address / word limit (0 = none)
//   s_stream                   : weight stream (slave side)
//   mem2_data_o                : packed word, lane 0 at the LSBs
//   wr_addrs_mem2_o            : write address
//   wr_mem2_ld_o               : one-cycle write enable
//   busy_o, done_o             : status
//   words_written_o            : words written since the last start
//   overflow_o                 : sticky, weights offered after the limit
module weight_mem_writer #(
  parameter int N_ROWS_ARRAY = 16,
  parameter int F_WIDTH      = 8,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                            clk_i,
  input  logic                            rd_weight_rst,
  input  logic                            start_i,
  input  logic [ADDR_WIDTH-1:0]           base_addr_i,
  input  logic [ADDR_WIDTH-1:0]           max_words_i,
  weight_mem_writer_if.slave              s_stream,
  output logic [N_ROWS_ARRAY*F_WIDTH-1:0] mem2_data_o,
  output logic [ADDR_WIDTH-1:0]           wr_addrs_mem2_o,
  output logic                            wr_mem2_ld_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [ADDR_WIDTH-1:0]           words_written_o,
  output logic                            overflow_o
);

  localparam int LW = (N_ROWS_ARRAY > 1) ? $clog2(N_ROWS_ARRAY) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(N_ROWS_ARRAY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PACK  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                            state;
  logic [N_ROWS_ARRAY*F_WIDTH-1:0]   pack_buf;
  logic [N_ROWS_ARRAY*F_WIDTH-1:0]   packed_next;
  logic [LW-1:0]                     lane_cnt;
  logic [ADDR_WIDTH-1:0]             addr;
  logic [ADDR_WIDTH-1:0]             max_words;
  logic [ADDR_WIDTH-1:0]             words_next;
  logic                              last_seen;

  // Ready is a pure decode of the state register, so reset (which forces
  // IDLE asynchronously) drops it immediately.
  assign s_stream.s_ready_o = (state == S_PACK);
  assign words_next = words_written_o + ADDR_WIDTH'(1);

  // The buffer is cleared after every write, so lanes above the current
  // one are already zero; a short final word comes out zero-filled.
  always_comb begin
    packed_next = pack_buf;
    for (int j = 0; j < N_ROWS_ARRAY; j++) begin
      if (lane_cnt == LW'(j)) packed_next[j*F_WIDTH +: F_WIDTH] = s_stream.s_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) begin
      state           <= S_IDLE;
      pack_buf        <= '0;
      lane_cnt        <= '0;
      addr            <= '0;
      max_words       <= '0;
      last_seen       <= 1'b0;
      mem2_data_o     <= '0;
      wr_addrs_mem2_o <= '0;
      wr_mem2_ld_o    <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      words_written_o <= '0;
      overflow_o      <= 1'b0;
    end else begin
      wr_mem2_ld_o <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state           <= S_PACK;
            busy_o          <= 1'b1;
            pack_buf        <= '0;
            lane_cnt        <= '0;
            addr            <= base_addr_i;
            max_words       <= max_words_i;
            last_seen       <= 1'b0;
            words_written_o <= '0;
            overflow_o      <= 1'b0;
          end
        end
        S_PACK: begin
          if (s_stream.s_valid_i) begin
            pack_buf <= packed_next;
            if (lane_cnt == LAST_LANE || s_stream.s_last_i) begin
              state           <= S_WRITE;
              mem2_data_o     <= packed_next;
              wr_addrs_mem2_o <= addr;
              wr_mem2_ld_o    <= 1'b1;
              last_seen       <= s_stream.s_last_i;
            end else begin
              lane_cnt <= lane_cnt + LW'(1);
            end
          end
        end
        S_WRITE: begin
          addr            <= addr + ADDR_WIDTH'(1);
          words_written_o <= words_next;
          pack_buf        <= '0;
          lane_cnt        <= '0;
          if (last_seen || (max_words != '0 && words_next == max_words)) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            state <= S_PACK;
          end
        end
        S_DONE: begin
          // Only the word limit reaches DONE without last_seen.
          if (!last_seen && s_stream.s_valid_i) overflow_o <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
